tdm_demux: RTL and testbench

- Receive-side counterpart of the team's 4:1 gate-level mux when that mux is driven by a rotating select as a time-division serializer.
- Takes the serialized sample stream plus a frame-sync marker and re-assembles NCH parallel channels.
- Emits one complete frame per valid-pulse.
- Sits directly downstream of the TDM serializer or link receiver; feeds per-channel consumers.

---
 rtl/tdm_demux_pkg.sv | 38 +++
 rtl/tdm_demux_slot_counter.sv | 41 ++++
 rtl/tdm_demux.sv | 155 +++++++++++++++
 tb/tb_tdm_demux.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer (package tdm_pkg).
// frame_parity is used only when TDM_DEMUX_PARITY_EN is defined.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 1;

    // Upper bounds for the generic parity helper; frames must fit within them.
    localparam int PAR_MAX_W    = 32;
    localparam int PAR_MAX_CH   = 64;
    localparam int PAR_MAX_BITS = 256;

    function automatic logic [PAR_MAX_W-1:0] frame_parity(
        input logic [PAR_MAX_BITS-1:0] frame,
        input int                      nch,
        input int                      w
    );
        logic [PAR_MAX_BITS-1:0] rest;
        logic [PAR_MAX_W-1:0]    mask;
        logic [PAR_MAX_W-1:0]    p;
        rest = frame;
        mask = PAR_MAX_W'((64'd1 << w) - 64'd1);
        p    = '0;
        for (int c = 0; c < PAR_MAX_CH; c++) begin
            if (c < nch) begin
                p    = p ^ (rest[PAR_MAX_W-1:0] & mask);
                rest = rest >> w;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Modulo-N slot counter: clear beats load-to-1 (resync), which beats a count step.
// Produces the current slot index and a last-slot flag.
module tdm_slot_counter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] sel,
    output logic          last
);

    logic [SW-1:0] sel_q;
    logic [SW-1:0] sel_d;

    assign last = (sel_q == SW'(N - 1));
    assign sel  = sel_q;

    always_comb begin
        sel_d = sel_q;
        if (clr) begin
            sel_d = '0;
        end else if (load1) begin
            sel_d = SW'(1);
        end else if (en) begin
            sel_d = last ? '0 : sel_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Re-assembles NCH parallel channels from a serialized TDM stream with frame sync.
// Define TDM_DEMUX_PARITY_EN to add a trailing XOR-parity slot and the par_err output.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int NCH = DEF_NCH,
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW = $clog2(NCH + 1)
`else
    localparam int SW = $clog2(NCH)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_fsync,
    output logic [NCH*W-1:0] out,
    output logic             out_valid,
    output logic [SW-1:0]    sel,
    output logic             locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic             par_err,
`endif
    output logic             sync_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NSLOT = NCH + 1;
`else
    localparam int NSLOT = NCH;
`endif

    tdm_state_e              state_q, state_d;
    logic [NCH-1:0][W-1:0]   shadow_q, shadow_d;
    logic [NCH*W-1:0]        out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic                    par_err_q, par_err_d;
`endif

    logic                    cnt_en;
    logic                    cnt_load;
    logic                    cnt_clr;
    logic                    cnt_last;
    logic                    slot0;

    tdm_slot_counter #(
        .N  (NSLOT),
        .SW (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .load1 (cnt_load),
        .clr   (cnt_clr),
        .sel   (sel),
        .last  (cnt_last)
    );

    assign slot0 = (sel == '0);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d   = 1'b0;
`endif
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        cnt_clr     = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_fsync) begin
                        shadow_d[0] = in_data;
                        cnt_load    = 1'b1;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (in_fsync == slot0) begin
                        for (int k = 0; k < NCH; k++) begin
                            if (sel == SW'(k)) begin
                                shadow_d[k] = in_data;
                            end
                        end
                        cnt_en = 1'b1;
                        if (cnt_last) begin
`ifdef TDM_DEMUX_PARITY_EN
                            // Last slot is the parity word; data slots are all in shadow_q.
                            if (in_data == W'(frame_parity(PAR_MAX_BITS'(shadow_q), NCH, W))) begin
                                out_d       = shadow_q;
                                out_valid_d = 1'b1;
                            end else begin
                                par_err_d   = 1'b1;
                            end
`else
                            out_d       = shadow_d;
                            out_valid_d = 1'b1;
`endif
                        end
                    end else if (in_fsync) begin
                        // Early sync: restart the frame with this sample as slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = in_data;
                        cnt_load    = 1'b1;
                    end else begin
                        sync_err_d = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = (state_q == LOCK);
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a frame-level model queues expected output events,
// a monitor pops them when the DUT flags an output. Works with or without TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;

    localparam int W   = 1;
    localparam int NCH = 4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int NSLOT = NCH + 1;
`else
    localparam int NSLOT = NCH;
`endif
    localparam int SW = $clog2(NSLOT);

    localparam int EV_OUT  = 1;
    localparam int EV_SERR = 2;
    localparam int EV_PERR = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_fsync = 1'b0;
    logic [NCH*W-1:0] out;
    logic             out_valid;
    logic [SW-1:0]    sel;
    logic             locked;
    logic             sync_err;
    logic             par_err_w;

    tdm_demux #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_fsync  (in_fsync),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .locked    (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .par_err   (par_err_w),
`endif
        .sync_err  (sync_err)
    );

`ifndef TDM_DEMUX_PARITY_EN
    assign par_err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int               kind;
        logic [NCH*W-1:0] val;
    } ev_t;

    ev_t              exp_q[$];
    int               vectors = 0;
    int               miscompares = 0;

    bit               m_lock = 1'b0;
    logic [W-1:0]     m_frame[$];
    int               exp_sel = 0;
    bit               exp_locked = 1'b0;
    logic [NCH*W-1:0] cur_out = '0;
    ev_t              mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] par_of(input logic [NCH*W-1:0] f);
        logic [W-1:0] p = '0;
        for (int k = 0; k < NCH; k++) p ^= f[k*W +: W];
        return p;
    endfunction

    // Frame-level reference: collect slot samples in a queue, judge a frame when it is full.
    task automatic model_step(input logic [W-1:0] d, input bit v, input bit fs, input bit r);
        if (!r) begin
            m_lock = 1'b0;
            m_frame.delete();
        end else if (v) begin
            if (!m_lock) begin
                if (fs) begin
                    m_lock = 1'b1;
                    m_frame.delete();
                    m_frame.push_back(d);
                end
            end else if (fs == (m_frame.size() == 0)) begin
                m_frame.push_back(d);
                if (m_frame.size() == NSLOT) begin
                    logic [NCH*W-1:0] fr = '0;
                    for (int k = 0; k < NCH; k++) fr[k*W +: W] = m_frame[k];
`ifdef TDM_DEMUX_PARITY_EN
                    if (par_of(fr) == m_frame[NCH]) exp_q.push_back('{kind: EV_OUT, val: fr});
                    else exp_q.push_back('{kind: EV_PERR, val: '0});
`else
                    exp_q.push_back('{kind: EV_OUT, val: fr});
`endif
                    m_frame.delete();
                end
            end else if (fs) begin
                exp_q.push_back('{kind: EV_SERR, val: '0});
                m_frame.delete();
                m_frame.push_back(d);
            end else begin
                exp_q.push_back('{kind: EV_SERR, val: '0});
                m_lock = 1'b0;
                m_frame.delete();
            end
        end
        exp_locked = m_lock;
        exp_sel    = m_frame.size();
    endtask

    task automatic apply(input logic [W-1:0] d, input bit v, input bit fs, input bit r);
        @(negedge clk);
        in_data  = d;
        in_valid = v;
        in_fsync = fs;
        rst_n    = r;
        model_step(d, v, fs, r);
    endtask

    task automatic send_frame(input logic [NCH*W-1:0] f, input bit gaps, input int start);
        for (int s = start; s < NSLOT; s++) begin
            if (gaps && s == 2) apply('0, 1'b0, 1'b0, 1'b1);
            if (s < NCH) apply(f[s*W +: W], 1'b1, s == 0, 1'b1);
            else apply(par_of(f), 1'b1, 1'b0, 1'b1);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b0) begin
                cur_out = '0;
                check("rst_out", 64'(out), 64'd0);
                check("rst_flags", {60'd0, out_valid, sync_err, par_err_w, locked}, 64'd0);
                check("rst_sel", 64'(sel), 64'd0);
            end else begin
                if (out_valid | sync_err | par_err_w) begin
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        check("event", {61'd0, par_err_w, sync_err, out_valid}, 64'(mon_e.kind));
                        if (mon_e.kind == EV_OUT) cur_out = mon_e.val;
                    end else begin
                        check("spurious_event", {61'd0, par_err_w, sync_err, out_valid}, 64'd0);
                    end
                end else if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("missing_event", 64'd0, 64'(mon_e.kind));
                end
                check("out", 64'(out), 64'(cur_out));
                check("sel", 64'(sel), 64'(exp_sel));
                check("locked", 64'(locked), 64'(exp_locked));
            end
        end
    end

    initial begin
        logic [NCH*W-1:0] f;
        repeat (2) apply('0, 1'b0, 1'b0, 1'b0);

        // Basic frame 1,0,1,1 -> 4'b1101
        send_frame(4'b1101, 1'b0, 0);
        apply('0, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames with a mid-frame gap
        send_frame(4'hA, 1'b1, 0);
        send_frame(4'h5, 1'b1, 0);
        send_frame(4'hF, 1'b1, 0);
        apply('0, 1'b0, 1'b0, 1'b1);

        // Early sync at sel=2, then complete the new frame
        apply(1'b0, 1'b1, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(4'b0111, 1'b0, 1);

        // Missing sync, dropped samples, then recovery
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(4'b0010, 1'b0, 0);

        // Reset mid-frame at sel=2
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        apply('0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1001, 1'b0, 0);

`ifdef TDM_DEMUX_PARITY_EN
        // Good parity then bad parity on the same frame
        f = 4'b1101;
        send_frame(f, 1'b0, 0);
        for (int s = 0; s < NCH; s++) apply(f[s*W +: W], 1'b1, s == 0, 1'b1);
        apply(~par_of(f), 1'b1, 1'b0, 1'b1);
`endif

        // Randomized traffic with occasional framing faults and resets
        for (int i = 0; i < 3000; i++) begin
            bit r, v, fs;
            r  = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 3) != 0);
            fs = m_lock ? (m_frame.size() == 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) fs = ~fs;
            apply(W'($urandom), v, fs, r);
        end

        repeat (3) apply('0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
